// File: rtl/rv_wb_if.sv
// Writeback unit bus bundle: ALU results, load issue, memory response and register-file write port.
// The master modport is the writeback unit; the slave modport is its surroundings.
interface rv_wb_if;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        alu_ready_o;

    logic        ld_issue_valid_i;
    logic [4:0]  ld_issue_rd_i;
    logic [2:0]  ld_issue_funct3_i;
    logic [1:0]  ld_issue_offset_i;
    logic        ld_issue_ready_o;

    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        mem_rsp_ready_o;

    logic        rf_wr_en_o;
    logic [4:0]  rf_rd_addr_o;
    logic [31:0] rf_wr_data_o;

    logic        ld_pending_o;
    logic [4:0]  ld_pending_rd_o;
    logic        ld_misalign_o;

    modport master (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        output alu_ready_o,
        input  ld_issue_valid_i, ld_issue_rd_i, ld_issue_funct3_i, ld_issue_offset_i,
        output ld_issue_ready_o,
        input  mem_rsp_valid_i, mem_rsp_data_i,
        output mem_rsp_ready_o,
        output rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o,
        output ld_pending_o, ld_pending_rd_o, ld_misalign_o
    );

    modport slave (
        output alu_valid_i, alu_rd_i, alu_data_i,
        input  alu_ready_o,
        output ld_issue_valid_i, ld_issue_rd_i, ld_issue_funct3_i, ld_issue_offset_i,
        input  ld_issue_ready_o,
        output mem_rsp_valid_i, mem_rsp_data_i,
        input  mem_rsp_ready_o,
        input  rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o,
        input  ld_pending_o, ld_pending_rd_o, ld_misalign_o
    );
endinterface

// File: rtl/rv_wb_unit.sv
// Writeback unit: merges ALU results (buffered in a small FIFO) with load responses into one registered RF write.
// Optional feature macro: RV_WB_MISALIGN_CHK_EN (misaligned loads write 0 and pulse ld_misalign_o).
module rv_wb_unit #(
    parameter int unsigned ALU_FIFO_DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    rv_wb_if.master  bus
);
    localparam int unsigned PTR_W = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } alu_entry_t;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT_RSP = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_ld_rd;
    logic [2:0]       r_ld_funct3;
    logic [1:0]       r_ld_offset;

    alu_entry_t       r_fifo [ALU_FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             r_wr_en;
    logic [4:0]       r_wr_addr;
    logic [31:0]      r_wr_data;
    logic             r_misalign;

    logic             w_issue_ready;
    logic             w_rsp_ready;
    logic             w_pending;
    logic [4:0]       w_pending_rd;
    logic             w_alu_ready;
    logic             w_empty;
    logic             w_issue_hs;
    logic             w_rsp_hs;
    logic             w_alu_keep;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ld_data;
    logic             w_misalign;

    // Load FSM: state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Load FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_issue_hs) w_state_nxt = S_WAIT_RSP;
            S_WAIT_RSP: if (w_rsp_hs)   w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Load FSM: state-decoded outputs
    always_comb begin
        w_issue_ready = 1'b0;
        w_rsp_ready   = 1'b0;
        w_pending     = 1'b0;
        w_pending_rd  = 5'd0;
        case (r_state)
            S_IDLE:     w_issue_ready = 1'b1;
            S_WAIT_RSP: begin
                w_rsp_ready  = 1'b1;
                w_pending    = 1'b1;
                w_pending_rd = r_ld_rd;
            end
            default:    w_issue_ready = 1'b0;
        endcase
    end

    assign w_empty     = (r_count == '0);
    assign w_alu_ready = (r_count != CNT_W'(ALU_FIFO_DEPTH));
    assign w_issue_hs  = bus.ld_issue_valid_i && w_issue_ready;
    assign w_rsp_hs    = bus.mem_rsp_valid_i && w_rsp_ready;
    // Results to x0 are accepted but never written or buffered.
    assign w_alu_keep  = bus.alu_valid_i && w_alu_ready && (bus.alu_rd_i != 5'd0);
    assign w_pop       = !w_rsp_hs && !w_empty;
    assign w_push      = w_alu_keep && (w_rsp_hs || !w_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_rd     <= 5'd0;
            r_ld_funct3 <= 3'd0;
            r_ld_offset <= 2'd0;
        end else if (w_issue_hs) begin
            r_ld_rd     <= bus.ld_issue_rd_i;
            r_ld_funct3 <= bus.ld_issue_funct3_i;
            r_ld_offset <= bus.ld_issue_offset_i;
        end
    end

    // Load formatting: byte/halfword select and extension
    assign w_byte = 8'(bus.mem_rsp_data_i >> {r_ld_offset, 3'b000});
    assign w_half = r_ld_offset[1] ? bus.mem_rsp_data_i[31:16] : bus.mem_rsp_data_i[15:0];

    always_comb begin
        w_ld_data  = bus.mem_rsp_data_i;
        w_misalign = 1'b0;
        case (r_ld_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = bus.mem_rsp_data_i;
        endcase
`ifdef RV_WB_MISALIGN_CHK_EN
        case (r_ld_funct3)
            3'b000, 3'b100: w_misalign = 1'b0;
            3'b001, 3'b101: w_misalign = r_ld_offset[0];
            default:        w_misalign = (r_ld_offset != 2'd0);
        endcase
        if (w_misalign) w_ld_data = 32'd0;
`endif
    end

    // Write-port arbitration: load response, then FIFO head, then ALU bypass
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 5'd0;
            r_wr_data  <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 5'd0;
            r_wr_data  <= 32'd0;
            r_misalign <= 1'b0;
            if (w_rsp_hs) begin
                r_wr_en    <= (r_ld_rd != 5'd0);
                r_wr_addr  <= r_ld_rd;
                r_wr_data  <= w_ld_data;
                r_misalign <= w_misalign;
            end else if (!w_empty) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_fifo[r_rd_ptr].rd;
                r_wr_data <= r_fifo[r_rd_ptr].data;
            end else if (w_alu_keep) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= bus.alu_rd_i;
                r_wr_data <= bus.alu_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= '{rd: bus.alu_rd_i, data: bus.alu_data_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.alu_ready_o      = w_alu_ready;
    assign bus.ld_issue_ready_o = w_issue_ready;
    assign bus.mem_rsp_ready_o  = w_rsp_ready;
    assign bus.rf_wr_en_o       = r_wr_en;
    assign bus.rf_rd_addr_o     = r_wr_addr;
    assign bus.rf_wr_data_o     = r_wr_data;
    assign bus.ld_pending_o     = w_pending;
    assign bus.ld_pending_rd_o  = w_pending_rd;
    assign bus.ld_misalign_o    = r_misalign;
endmodule

// File: tb/tb_rv_wb_unit.sv
// Bench for rv_wb_unit: directed vector table, multi-cycle corner sequences and a queue-based random model.
module tb_rv_wb_unit;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv_wb_if bus ();

    rv_wb_unit #(.ALU_FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        m_q[$];
    logic        m_pend;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    int          n_mis_pulses;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        iv;
        logic [4:0]  ird;
        logic [2:0]  if3;
        logic [1:0]  ioff;
        logic        rv;
        logic [31:0] rdat;
        logic        e_en;
        logic [4:0]  e_rd;
        logic [31:0] e_d;
        logic        e_pend;
        logic [4:0]  e_prd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic model_mis(input logic [2:0] f3, input logic [1:0] off);
`ifdef RV_WB_MISALIGN_CHK_EN
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) == 1;
        return off != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Load value from word, type and byte offset, by plain arithmetic.
    function automatic logic [31:0] model_fmt(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
        if (model_mis(f3, off)) return 32'd0;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic iv, input logic [4:0] ird, input logic [2:0] if3, input logic [1:0] ioff,
                         input logic rv, input logic [31:0] rdat);
        bus.alu_valid_i       = av;
        bus.alu_rd_i          = ard;
        bus.alu_data_i        = ad;
        bus.ld_issue_valid_i  = iv;
        bus.ld_issue_rd_i     = ird;
        bus.ld_issue_funct3_i = if3;
        bus.ld_issue_offset_i = ioff;
        bus.mem_rsp_valid_i   = rv;
        bus.mem_rsp_data_i    = rdat;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_wr_en",     32'(bus.rf_wr_en_o), 32'd0);
        chk("rst_rd_addr",   32'(bus.rf_rd_addr_o), 32'd0);
        chk("rst_wr_data",   bus.rf_wr_data_o, 32'd0);
        chk("rst_pending",   32'(bus.ld_pending_o), 32'd0);
        chk("rst_misalign",  32'(bus.ld_misalign_o), 32'd0);
        chk("rst_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        chk("rst_iss_ready", 32'(bus.ld_issue_ready_o), 32'd1);
        rst = 1'b0;
        m_q.delete();
        m_pend = 1'b0;
        m_rd = 5'd0;
        m_f3 = 3'd0;
        m_off = 2'd0;
    endtask

    // One clock with model-predicted handshakes, writes and load status.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic iv, input logic [4:0] ird, input logic [2:0] if3, input logic [1:0] ioff,
                         input logic rv, input logic [31:0] rdat);
        logic ahs, keep, ihs, rhs, direct, e_en, e_mis;
        logic [4:0] e_rd;
        logic [31:0] e_d;
        ent_t e;
        drive(av, ard, ad, iv, ird, if3, ioff, rv, rdat);
        chk("alu_ready", 32'(bus.alu_ready_o), 32'(m_q.size() < DEPTH));
        chk("iss_ready", 32'(bus.ld_issue_ready_o), 32'(!m_pend));
        chk("rsp_ready", 32'(bus.mem_rsp_ready_o), 32'(m_pend));
        ahs = av && (m_q.size() < DEPTH);
        keep = ahs && (ard != 5'd0);
        ihs = iv && !m_pend;
        rhs = rv && m_pend;
        direct = 1'b0;
        e_en = 1'b0; e_rd = 5'd0; e_d = 32'd0; e_mis = 1'b0;
        if (rhs) begin
            e_en = (m_rd != 5'd0);
            e_rd = m_rd;
            e_d = model_fmt(m_f3, m_off, rdat);
            e_mis = model_mis(m_f3, m_off);
            m_pend = 1'b0;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            e_en = 1'b1; e_rd = e.rd; e_d = e.d;
        end else if (keep) begin
            e_en = 1'b1; e_rd = ard; e_d = ad;
            direct = 1'b1;
        end
        if (keep && !direct) m_q.push_back('{rd: ard, d: ad});
        if (ihs) begin
            m_pend = 1'b1; m_rd = ird; m_f3 = if3; m_off = ioff;
        end
        @(posedge clk); #1;
        if (bus.ld_misalign_o) n_mis_pulses++;
        chk("wr_en", 32'(bus.rf_wr_en_o), 32'(e_en));
        if (e_en) begin
            chk("wr_addr", 32'(bus.rf_rd_addr_o), 32'(e_rd));
            chk("wr_data", bus.rf_wr_data_o, e_d);
        end
        chk("ld_pending", 32'(bus.ld_pending_o), 32'(m_pend));
        chk("ld_pending_rd", 32'(bus.ld_pending_rd_o), m_pend ? 32'(m_rd) : 32'd0);
        chk("ld_misalign", 32'(bus.ld_misalign_o), 32'(e_mis));
    endtask

    vec_t vecs[18];
    logic reached;

    initial begin
        rst = 1'b1;
        n_mis_pulses = 0;

        //               av ard    ad           iv ird   f3    off  rv rdat           e_en e_rd  e_d            pend prd
        vecs[0]  = '{1, 5'd5, 32'h11,  0, 5'd0, 3'd0, 2'd0, 0, 32'h0,          1, 5'd5, 32'h11,          0, 5'd0};
        vecs[1]  = '{1, 5'd6, 32'h22,  0, 5'd0, 3'd0, 2'd0, 0, 32'h0,          1, 5'd6, 32'h22,          0, 5'd0};
        vecs[2]  = '{0, 5'd0, 32'h0,   0, 5'd0, 3'd0, 2'd0, 0, 32'h0,          0, 5'd0, 32'h0,           0, 5'd0};
        vecs[3]  = '{0, 5'd0, 32'h0,   1, 5'd7, 3'd0, 2'd3, 0, 32'h0,          0, 5'd0, 32'h0,           1, 5'd7};
        vecs[4]  = '{0, 5'd0, 32'h0,   0, 5'd0, 3'd0, 2'd0, 1, 32'h80FF_1234,  1, 5'd7, 32'hFFFF_FF80,   0, 5'd0};
        vecs[5]  = '{0, 5'd0, 32'h0,   1, 5'd7, 3'd4, 2'd3, 0, 32'h0,          0, 5'd0, 32'h0,           1, 5'd7};
        vecs[6]  = '{0, 5'd0, 32'h0,   0, 5'd0, 3'd0, 2'd0, 1, 32'h80FF_1234,  1, 5'd7, 32'h0000_0080,   0, 5'd0};
        vecs[7]  = '{0, 5'd0, 32'h0,   1, 5'd4, 3'd2, 2'd0, 0, 32'h0,          0, 5'd0, 32'h0,           1, 5'd4};
        vecs[8]  = '{1, 5'd3, 32'hA,   0, 5'd0, 3'd0, 2'd0, 1, 32'h1234_5678,  1, 5'd4, 32'h1234_5678,   0, 5'd0};
        vecs[9]  = '{0, 5'd0, 32'h0,   0, 5'd0, 3'd0, 2'd0, 0, 32'h0,          1, 5'd3, 32'hA,           0, 5'd0};
        vecs[10] = '{0, 5'd0, 32'h0,   0, 5'd0, 3'd0, 2'd0, 0, 32'h0,          0, 5'd0, 32'h0,           0, 5'd0};
        vecs[11] = '{1, 5'd0, 32'h99,  1, 5'd0, 3'd2, 2'd0, 0, 32'h0,          0, 5'd0, 32'h0,           1, 5'd0};
        vecs[12] = '{0, 5'd0, 32'h0,   0, 5'd0, 3'd0, 2'd0, 1, 32'hDEAD_BEEF,  0, 5'd0, 32'h0,           0, 5'd0};
        vecs[13] = '{0, 5'd0, 32'h0,   0, 5'd0, 3'd0, 2'd0, 0, 32'h0,          0, 5'd0, 32'h0,           0, 5'd0};
        vecs[14] = '{0, 5'd0, 32'h0,   1, 5'd9, 3'd1, 2'd2, 0, 32'h0,          0, 5'd0, 32'h0,           1, 5'd9};
        vecs[15] = '{0, 5'd0, 32'h0,   0, 5'd0, 3'd0, 2'd0, 1, 32'h8001_7FFF,  1, 5'd9, 32'hFFFF_8001,   0, 5'd0};
        vecs[16] = '{0, 5'd0, 32'h0,   1, 5'd10, 3'd5, 2'd0, 0, 32'h0,         0, 5'd0, 32'h0,           1, 5'd10};
        vecs[17] = '{0, 5'd0, 32'h0,   0, 5'd0, 3'd0, 2'd0, 1, 32'h8001_F00F,  1, 5'd10, 32'h0000_F00F,  0, 5'd0};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].iv, vecs[i].ird, vecs[i].if3,
                  vecs[i].ioff, vecs[i].rv, vecs[i].rdat);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_wr_en", i), 32'(bus.rf_wr_en_o), 32'(vecs[i].e_en));
            if (vecs[i].e_en) begin
                chk($sformatf("vec%0d_wr_addr", i), 32'(bus.rf_rd_addr_o), 32'(vecs[i].e_rd));
                chk($sformatf("vec%0d_wr_data", i), bus.rf_wr_data_o, vecs[i].e_d);
            end
            chk($sformatf("vec%0d_pending", i), 32'(bus.ld_pending_o), 32'(vecs[i].e_pend));
            chk($sformatf("vec%0d_pending_rd", i), 32'(bus.ld_pending_rd_o), 32'(vecs[i].e_prd));
            chk($sformatf("vec%0d_iss_ready", i), 32'(bus.ld_issue_ready_o), 32'(!vecs[i].e_pend));
            chk($sformatf("vec%0d_alu_ready", i), 32'(bus.alu_ready_o), 32'd1);
        end

        // Fill the FIFO behind back-to-back load responses, then drain it.
        do_reset();
        reached = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            cycle(1'b1, 5'(11 + k), 32'h100 + 32'(k), !m_pend, 5'd1, 3'd2, 2'd0, m_pend, 32'h5000 + 32'(k));
            if (!bus.alu_ready_o) reached = 1'b1;
        end
        chk("fifo_full_reached", 32'(reached), 32'd1);
        chk("fifo_full_depth", 32'(m_q.size()), 32'(DEPTH));
        for (int k = 0; k < 4; k++)
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        chk("fifo_drained", 32'(bus.alu_ready_o), 32'd1);

        // Reset while a load is outstanding and one ALU result is buffered.
        do_reset();
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 3'd2, 2'd0, 1'b0, 32'd0);
        cycle(1'b1, 5'd12, 32'hAB, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h77);
        cycle(1'b1, 5'd13, 32'hCD, 1'b1, 5'd8, 3'd2, 2'd0, 1'b0, 32'd0);
        chk("pre_rst_pending", 32'(bus.ld_pending_o), 32'd1);
        do_reset();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        chk("post_rst_no_write", 32'(bus.rf_wr_en_o), 32'd0);

`ifdef RV_WB_MISALIGN_CHK_EN
        do_reset();
        n_mis_pulses = 0;
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 3'd2, 2'd2, 1'b0, 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'hCAFE_F00D);
        chk("mis_lw_data", bus.rf_wr_data_o, 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        chk("mis_pulse_count", 32'(n_mis_pulses), 32'd1);
`endif

        // Random traffic against the queue model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            cycle(1'($urandom), 5'($urandom % 8), $urandom, 1'($urandom), 5'($urandom % 8),
                  3'($urandom), 2'($urandom), 1'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
